// File: rtl/iob_rom_np.sv
// iob_rom_np: several read ports share one synchronous single-port ROM.
// A combinational arbiter picks one requester per cycle, using either
// round-robin or fixed priority. The read response (rvalid, rsel, data)
// appears one cycle after the grant.

// iob_rom_sp: synchronous single-port ROM. Word i holds INIT_BASE + i, so
// the image is fully defined by parameters and needs no load step.
module iob_rom_sp #(
    parameter              HEXFILE   = "none",
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 10,
    parameter logic [63:0] INIT_BASE = 64'd0
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] r_data
);

    // Registered read. The output keeps its last word while the ROM is idle.
    always_ff @(posedge clk) begin
        if (en) begin
            r_data <= DATA_W'(INIT_BASE) + DATA_W'(addr);
        end
    end

endmodule

module iob_rom_np #(
    parameter              HEXFILE   = "none",
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 10,
    parameter int          N_PORTS   = 2,
    parameter int          RR_EN     = 1,
    parameter logic [63:0] INIT_BASE = 64'd0,
    localparam int         SEL_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic [N_PORTS-1:0]        en_i,
    input  logic [N_PORTS*ADDR_W-1:0] addr_i,
    output logic [N_PORTS-1:0]        ready_o,
    output logic [N_PORTS-1:0]        rvalid_o,
    output logic [SEL_W-1:0]          rsel_o,
    output logic [DATA_W-1:0]         r_data_o
);

    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   next_ptr;
    logic [N_PORTS-1:0] grant;
    logic               any_grant;
    logic [ADDR_W-1:0]  rom_addr;

    // Grant the first requester at or after ptr, with wrap-around. With
    // fixed priority ptr stays at 0, so the same search yields lowest-index-wins.
    always_comb begin
        int                 idx;
        logic [N_PORTS-1:0] onehot;
        grant     = '0;
        win_idx   = '0;
        any_grant = 1'b0;
        idx       = 0;
        onehot    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx    = (int'(ptr) + i) % N_PORTS;
            onehot = N_PORTS'(1) << idx;
            if (!any_grant && ((en_i & onehot) != '0)) begin
                any_grant = 1'b1;
                grant     = onehot;
                win_idx   = SEL_W'(idx);
            end
        end
    end

    // Route the winning port's address to the ROM.
    always_comb begin
        rom_addr = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (grant[k]) begin
                rom_addr = addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign next_ptr = SEL_W'((int'(win_idx) + 1) % N_PORTS);

    // A single port is always ready; otherwise ready is the grant itself.
    generate
        if (N_PORTS == 1) begin : g_single
            assign ready_o = '1;
        end else begin : g_multi
            assign ready_o = grant;
        end
    endgenerate

    // Round-robin pointer: moves past the winner, holds when nothing is granted.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr <= '0;
        end else if ((RR_EN != 0) && any_grant) begin
            ptr <= next_ptr;
        end
    end

    // Read response: one-cycle valid pulse and the owning port index.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rvalid_o <= '0;
            rsel_o   <= '0;
        end else begin
            rvalid_o <= grant;
            if (any_grant) begin
                rsel_o <= win_idx;
            end
        end
    end

    iob_rom_sp #(
        .HEXFILE  (HEXFILE),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_BASE(INIT_BASE)
    ) u_rom (
        .clk   (clk_i),
        .en    (any_grant),
        .addr  (rom_addr),
        .r_data(r_data_o)
    );

endmodule

// File: tb/tb_iob_rom_np.sv
// Testbench for iob_rom_np: directed scenarios plus a randomized run checked
// against a request-queue model of the arbiter and the ROM image.
module tb_iob_rom_np;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int N_PORTS = 3;
    localparam int SEL_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_PORTS-1:0]        en, en_fp;
    logic [N_PORTS*ADDR_W-1:0] addr, addr_fp;
    logic [N_PORTS-1:0]        ready, rvalid, ready_fp, rvalid_fp;
    logic [SEL_W-1:0]          rsel, rsel_fp;
    logic [DATA_W-1:0]         rdata, rdata_fp;

    int checks = 0;
    int fails  = 0;

    iob_rom_np #(
        .HEXFILE("none"), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .N_PORTS(N_PORTS), .RR_EN(1), .INIT_BASE(64'h0100)
    ) dut (
        .clk_i(clk), .arst_i(rst), .en_i(en), .addr_i(addr),
        .ready_o(ready), .rvalid_o(rvalid), .rsel_o(rsel), .r_data_o(rdata)
    );

    iob_rom_np #(
        .HEXFILE("none"), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .N_PORTS(N_PORTS), .RR_EN(0), .INIT_BASE(64'h0100)
    ) dut_fp (
        .clk_i(clk), .arst_i(rst), .en_i(en_fp), .addr_i(addr_fp),
        .ready_o(ready_fp), .rvalid_o(rvalid_fp), .rsel_o(rsel_fp), .r_data_o(rdata_fp)
    );

    always #5 clk = ~clk;

    // ROM image as seen by a reader.
    function automatic logic [DATA_W-1:0] rom_word(input int a);
        return 16'h0100 + 16'(a);
    endfunction

    // Which requester wins: first set bit scanning from start (round-robin)
    // or from zero (fixed priority); -1 when nobody requests.
    function automatic int model_winner(input logic [2:0] req, input int start, input bit rr);
        int first;
        first = rr ? start : 0;
        for (int n = 0; n < 3; n++) begin
            if (req[(first + n) % 3]) return (first + n) % 3;
        end
        return -1;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        en    = '0;
        en_fp = '0;
        rst   = 1'b1;
        #2;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 3'b111;
        en_fp = '0;
        addr = {4'd3, 4'd2, 4'd1};
        addr_fp = {4'd3, 4'd2, 4'd1};
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 3'b000) begin fails++; $display("[TB] FAIL reset_rvalid: got %b expected 000", rvalid); end
        checks++;
        if (rsel !== 2'd0) begin fails++; $display("[TB] FAIL reset_rsel: got %0d expected 0", rsel); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 3'b001) begin fails++; $display("[TB] FAIL reset_first_ready: got %b expected 001", ready); end
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 3'b001 || rdata !== 16'h0101) begin
            fails++; $display("[TB] FAIL reset_first_read: got rvalid=%b data=%h expected 001/0101", rvalid, rdata);
        end
        @(negedge clk);
        en = '0;
    endtask

    task automatic test_round_robin();
        pulse_reset();
        @(negedge clk);
        en   = 3'b111;
        addr = {4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (ready !== 3'(1 << (i % 3))) begin
                fails++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", i, ready, 3'(1 << (i % 3)));
            end
            @(posedge clk); #1;
            checks++;
            if (rvalid !== 3'(1 << (i % 3)) || rsel !== 2'(i % 3) || rdata !== rom_word(i % 3 + 1)) begin
                fails++; $display("[TB] FAIL rr_read[%0d]: got rvalid=%b rsel=%0d data=%h expected %b/%0d/%h",
                                  i, rvalid, rsel, rdata, 3'(1 << (i % 3)), i % 3, rom_word(i % 3 + 1));
            end
            @(negedge clk);
        end
        en = '0;
    endtask

    task automatic test_single_port();
        @(negedge clk);
        en = 3'b010;
        addr[4 +: 4] = 4'd5;
        #1;
        checks++;
        if (ready !== 3'b010) begin fails++; $display("[TB] FAIL single_ready: got %b expected 010", ready); end
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 3'b010 || rsel !== 2'd1 || rdata !== 16'h0105) begin
            fails++; $display("[TB] FAIL single_read: got rvalid=%b rsel=%0d data=%h expected 010/1/0105", rvalid, rsel, rdata);
        end
        @(negedge clk);
        en = '0;
        #1;
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 3'b000 || rsel !== 2'd1) begin
            fails++; $display("[TB] FAIL single_idle: got rvalid=%b rsel=%0d expected 000/1", rvalid, rsel);
        end
    endtask

    task automatic test_pointer_wrap();
        @(negedge clk);
        en = 3'b100;
        addr[8 +: 4] = 4'd9;
        #1;
        checks++;
        if (ready !== 3'b100) begin fails++; $display("[TB] FAIL wrap_first: got %b expected 100", ready); end
        @(negedge clk);
        en = 3'b101;
        addr[0 +: 4] = 4'd7;
        #1;
        checks++;
        if (ready !== 3'b001) begin fails++; $display("[TB] FAIL wrap_port0: got %b expected 001", ready); end
        @(posedge clk); #1;
        checks++;
        if (rdata !== 16'h0107 || rsel !== 2'd0) begin
            fails++; $display("[TB] FAIL wrap_port0_data: got data=%h rsel=%0d expected 0107/0", rdata, rsel);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ready !== 3'b100) begin fails++; $display("[TB] FAIL wrap_port2: got %b expected 100", ready); end
        @(negedge clk);
        en = '0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        en = 3'b100;
        for (int i = 0; i < 3; i++) begin
            addr[8 +: 4] = 4'(i + 4);
            #1;
            checks++;
            if (ready !== 3'b100) begin fails++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected 100", i, ready); end
            @(posedge clk); #1;
            checks++;
            if (rvalid !== 3'b100 || rdata !== rom_word(i + 4)) begin
                fails++; $display("[TB] FAIL b2b_read[%0d]: got rvalid=%b data=%h expected 100/%h", i, rvalid, rdata, rom_word(i + 4));
            end
            @(negedge clk);
        end
        en = '0;
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        en_fp   = 3'b111;
        addr_fp = {4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ready_fp !== 3'b001) begin fails++; $display("[TB] FAIL fp_ready[%0d]: got %b expected 001", i, ready_fp); end
            @(posedge clk); #1;
            checks++;
            if (rvalid_fp !== 3'b001 || rdata_fp !== 16'h0101) begin
                fails++; $display("[TB] FAIL fp_read[%0d]: got rvalid=%b data=%h expected 001/0101", i, rvalid_fp, rdata_fp);
            end
            @(negedge clk);
        end
        en_fp = '0;
    endtask

    task automatic test_random();
        bit   [2:0]        pending;
        logic [3:0]        paddr [3];
        int                mptr;
        int                mrsel;
        int                w;
        logic [2:0]        exp_onehot;
        logic [DATA_W-1:0] exp_data;
        pending = '0;
        mptr    = 0;
        mrsel   = 0;
        for (int k = 0; k < 3; k++) paddr[k] = '0;
        pulse_reset();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (pending[k]) begin
                    if ($urandom_range(7) == 0) pending[k] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    pending[k] = 1'b1;
                    paddr[k]   = 4'($urandom_range(15));
                end
                en[k] = pending[k];
                addr[k*4 +: 4] = paddr[k];
            end
            w = model_winner(en, mptr, 1'b1);
            exp_onehot = (w < 0) ? 3'b000 : 3'(1 << w);
            #1;
            checks++;
            if (ready !== exp_onehot) begin
                fails++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", c, ready, exp_onehot);
            end
            @(posedge clk); #1;
            exp_data = '0;
            if (w >= 0) begin
                mptr       = (w + 1) % 3;
                mrsel      = w;
                exp_data   = rom_word(int'(paddr[w]));
                pending[w] = 1'b0;
            end
            checks++;
            if (rvalid !== exp_onehot || rsel !== 2'(mrsel)) begin
                fails++; $display("[TB] FAIL rand_resp[%0d]: got rvalid=%b rsel=%0d expected %b/%0d", c, rvalid, rsel, exp_onehot, mrsel);
            end
            if (w >= 0) begin
                checks++;
                if (rdata !== exp_data) begin
                    fails++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", c, rdata, exp_data);
                end
            end
        end
        @(negedge clk);
        en = '0;
    endtask

    task automatic test_reset_mid_read();
        pulse_reset();
        @(negedge clk);
        en = 3'b010;
        addr[4 +: 4] = 4'd6;
        #1;
        checks++;
        if (ready !== 3'b010) begin fails++; $display("[TB] FAIL midrst_ready: got %b expected 010", ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        en  = '0;
        #1;
        checks++;
        if (rvalid !== 3'b000 || rsel !== 2'd0) begin
            fails++; $display("[TB] FAIL midrst_clear: got rvalid=%b rsel=%0d expected 000/0", rvalid, rsel);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 3'b000) begin fails++; $display("[TB] FAIL midrst_no_valid: got %b expected 000", rvalid); end
        @(negedge clk);
        en   = 3'b111;
        addr = {4'd3, 4'd2, 4'd1};
        #1;
        checks++;
        if (ready !== 3'b001) begin fails++; $display("[TB] FAIL midrst_restart: got %b expected 001", ready); end
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 3'b001 || rdata !== 16'h0101) begin
            fails++; $display("[TB] FAIL midrst_read: got rvalid=%b data=%h expected 001/0101", rvalid, rdata);
        end
        @(negedge clk);
        en = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_port();
        test_pointer_wrap();
        test_back_to_back();
        test_fixed_priority();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
